// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared mode encodings, BHT counter type and helpers for branch resolution
package branch_pkg;

  // Branch/jump mode codes carried from decode; codes 11..15 are undefined and resolve as NONE
  typedef enum logic [3:0] {
    MODE_NONE = 4'd0,
    MODE_BEQ  = 4'd1,
    MODE_BNE  = 4'd2,
    MODE_BGEZ = 4'd3,
    MODE_BGTZ = 4'd4,
    MODE_BLEZ = 4'd5,
    MODE_BLTZ = 4'd6,
    MODE_BC1T = 4'd7,
    MODE_BC1F = 4'd8,
    MODE_J    = 4'd9,
    MODE_JR   = 4'd10
  } BranchModes;

  // Branch-and-link flavours; only BGEZ/BLTZ have an AL form
  typedef enum logic [1:0] {
    LINK_NONE   = 2'd0,
    LINK_BGEZAL = 2'd1,
    LINK_BLTZAL = 2'd2
  } LinkBranchModes;

  typedef logic [1:0] bht_ctr_t;

  // Weakly not-taken
  localparam bht_ctr_t BHT_INIT = 2'b01;

  // Flag- or FP-condition driven branches; these are the only modes that train the BHT
  function automatic logic is_conditional(BranchModes m);
    return (m >= MODE_BEQ) && (m <= MODE_BC1F);
  endfunction

endpackage

// File: rtl/branch_history_table.sv
// rtl/branch_history_table.sv - 2-bit saturating branch history table with one lookup and one update port
module branch_history_table
  import branch_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            lookup_taken,
  input  logic            upd_en,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken
);

  localparam int IW = $clog2(DEPTH);

  bht_ctr_t       bht_q [DEPTH];
  logic [IW-1:0]  rd_idx;
  logic [IW-1:0]  wr_idx;
  bht_ctr_t       upd_cur;
  bht_ctr_t       upd_d;
  logic           unused_pc_bits;

  // Word-aligned instruction addresses: drop the byte offset, keep the low index bits
  assign rd_idx = lookup_pc[IW+1:2];
  assign wr_idx = upd_pc[IW+1:2];
  assign unused_pc_bits = ^{lookup_pc[XLEN-1:IW+2], lookup_pc[1:0],
                            upd_pc[XLEN-1:IW+2], upd_pc[1:0]};

  // Read straight from the array, so a same-cycle update is not visible until the next cycle
  assign lookup_taken = bht_q[rd_idx][1];

  // Saturating step of the counter being trained
  always_comb begin
    upd_cur = bht_q[wr_idx];
    upd_d   = upd_cur;
    if (upd_taken) begin
      if (upd_cur != 2'b11) upd_d = upd_cur + 2'd1;
    end else begin
      if (upd_cur != 2'b00) upd_d = upd_cur - 2'd1;
    end
  end

  // Table storage: reinitialised on reset, one entry written per trained branch
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) bht_q[i] <= BHT_INIT;
    end else if (upd_en) begin
      bht_q[wr_idx] <= upd_d;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - branch/jump resolver with registered result, link write-back and BHT training
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 16,
  parameter int LINK_REG  = 31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      mode,
  input  logic            link,
  input  logic [XLEN-1:0] pc,
  input  logic [15:0]     offset,
  input  logic [25:0]     jump_target,
  input  logic [XLEN-1:0] jr_addr,
  input  logic            result_zero,
  input  logic            result_negative,
  input  logic            result_positive,
  input  logic            cp1_cond,
  input  logic            predicted_taken,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            lookup_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic            redirect,
  output logic [XLEN-1:0] branch_to,
  output logic            link_we,
  output logic [4:0]      link_addr,
  output logic [XLEN-1:0] link_data
);

  BranchModes      mode_e;
  LinkBranchModes  link_kind;
  logic            accept;
  logic            cond_d;
  logic            redirect_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_plus8;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] j_target;
  logic [XLEN-1:0] jr_target;
  logic [XLEN-1:0] branch_to_d;

  logic            valid_q;
  logic            taken_q;
  logic            redirect_q;
  logic            link_we_q;
  logic [XLEN-1:0] branch_to_q;
  logic [XLEN-1:0] link_data_q;

  assign mode_e = BranchModes'(mode);

  // One-entry output buffer: a new request may enter as the held result leaves
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  assign pc_plus4  = pc + XLEN'(4);
  assign pc_plus8  = pc + XLEN'(8);
  assign br_target = pc_plus4 + {{(XLEN-18){offset[15]}}, offset, 2'b00};
  assign j_target  = {pc_plus4[XLEN-1:28], jump_target, 2'b00};
  assign jr_target = jr_addr & ~(XLEN'(3));

  // Branch condition from ALU flags / FP condition; jumps always taken, unknown codes never
  always_comb begin
    cond_d = 1'b0;
    case (mode_e)
      MODE_BEQ:  cond_d = result_zero;
      MODE_BNE:  cond_d = !result_zero;
      MODE_BGEZ: cond_d = result_zero || result_positive;
      MODE_BGTZ: cond_d = result_positive;
      MODE_BLEZ: cond_d = result_zero || result_negative;
      MODE_BLTZ: cond_d = result_negative;
      MODE_BC1T: cond_d = cp1_cond;
      MODE_BC1F: cond_d = !cp1_cond;
      MODE_J:    cond_d = 1'b1;
      MODE_JR:   cond_d = 1'b1;
      default:   cond_d = 1'b0;
    endcase
  end

  // Resolved target and mispredict; jumps are never predicted by the front end so they always redirect
  always_comb begin
    redirect_d  = 1'b0;
    branch_to_d = pc_plus8;
    case (mode_e)
      MODE_J: begin
        redirect_d  = 1'b1;
        branch_to_d = j_target;
      end
      MODE_JR: begin
        redirect_d  = 1'b1;
        branch_to_d = jr_target;
      end
      default: begin
        if (is_conditional(mode_e)) begin
          redirect_d = cond_d != predicted_taken;
          if (cond_d) branch_to_d = br_target;
        end
      end
    endcase
  end

  // AL variants link unconditionally, whether or not the branch is taken
  always_comb begin
    link_kind = LINK_NONE;
    if (link && (mode_e == MODE_BGEZ)) link_kind = LINK_BGEZAL;
    if (link && (mode_e == MODE_BLTZ)) link_kind = LINK_BLTZAL;
  end

  // Output register: load on accept, clear valid once the consumer takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      taken_q     <= 1'b0;
      redirect_q  <= 1'b0;
      link_we_q   <= 1'b0;
      branch_to_q <= '0;
      link_data_q <= '0;
    end else if (accept) begin
      valid_q     <= 1'b1;
      taken_q     <= cond_d;
      redirect_q  <= redirect_d;
      link_we_q   <= link_kind != LINK_NONE;
      branch_to_q <= branch_to_d;
      link_data_q <= pc_plus8;
    end else if (out_ready) begin
      valid_q     <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign taken     = taken_q;
  assign redirect  = redirect_q;
  assign link_we   = link_we_q;
  assign branch_to = branch_to_q;
  assign link_data = link_data_q;
  assign link_addr = 5'(LINK_REG);

  branch_history_table #(
    .DEPTH (BHT_DEPTH),
    .XLEN  (XLEN)
  ) u_bht (
    .clk          (clk),
    .rst          (rst),
    .lookup_pc    (lookup_pc),
    .lookup_taken (lookup_taken),
    .upd_en       (accept && is_conditional(mode_e)),
    .upd_pc       (pc),
    .upd_taken    (cond_d)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - scoreboard bench for branch_resolve_unit
module tb_branch_resolve_unit;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  mode;
  logic        link;
  logic [31:0] pc;
  logic [15:0] offset;
  logic [25:0] jump_target;
  logic [31:0] jr_addr;
  logic        result_zero, result_negative, result_positive, cp1_cond, predicted_taken;
  logic [31:0] lookup_pc;
  logic        lookup_taken;
  logic        out_valid;
  logic        out_ready;
  logic        taken, redirect, link_we;
  logic [31:0] branch_to, link_data;
  logic [4:0]  link_addr;

  logic        ready_cmd = 1'b1;
  logic        rnd_bp = 1'b0;

  typedef struct {
    logic [3:0]  mode;
    logic        link;
    logic [31:0] pc;
    logic [15:0] off;
    logic [25:0] jt;
    logic [31:0] jr;
    logic        z, n, p, c, pred;
  } req_t;

  typedef struct {
    logic        taken;
    logic        redirect;
    logic [31:0] branch_to;
    logic        link_we;
    logic [31:0] link_data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(16), .LINK_REG(31)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .link(link), .pc(pc), .offset(offset), .jump_target(jump_target),
    .jr_addr(jr_addr), .result_zero(result_zero), .result_negative(result_negative),
    .result_positive(result_positive), .cp1_cond(cp1_cond), .predicted_taken(predicted_taken),
    .lookup_pc(lookup_pc), .lookup_taken(lookup_taken), .out_valid(out_valid),
    .out_ready(out_ready), .taken(taken), .redirect(redirect), .branch_to(branch_to),
    .link_we(link_we), .link_addr(link_addr), .link_data(link_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, want);
    end
  endtask

  // Single writer of out_ready, applied 2ns after the edge
  always @(posedge clk) begin
    #2;
    if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
    else        out_ready = ready_cmd;
  end

  // Scoreboard pop on every output handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("spurious_out", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("taken",     32'(taken),     32'(mon_e.taken));
        check("redirect",  32'(redirect),  32'(mon_e.redirect));
        check("branch_to", branch_to,      mon_e.branch_to);
        check("link_we",   32'(link_we),   32'(mon_e.link_we));
        check("link_addr", 32'(link_addr), 32'd31);
        check("link_data", link_data,      mon_e.link_data);
      end
    end
  end

  function automatic req_t mk_req(input logic [3:0] m, input logic lk, input logic [31:0] a,
                                  input logic [15:0] off, input logic [25:0] jt, input logic [31:0] jr,
                                  input logic z, input logic n, input logic p, input logic c,
                                  input logic pred);
    req_t r;
    r.mode = m; r.link = lk; r.pc = a; r.off = off; r.jt = jt; r.jr = jr;
    r.z = z; r.n = n; r.p = p; r.c = c; r.pred = pred;
    return r;
  endfunction

  function automatic exp_t mk_exp(input logic t, input logic rd, input logic [31:0] bt,
                                  input logic lw, input logic [31:0] ld);
    exp_t e;
    e.taken = t; e.redirect = rd; e.branch_to = bt; e.link_we = lw; e.link_data = ld;
    return e;
  endfunction

  // Reference behaviour for random traffic
  function automatic exp_t model(input req_t r);
    exp_t        e;
    logic        cnd;
    logic [31:0] nxt;
    int          so;
    nxt = r.pc + 32'd4;
    so  = int'($signed(r.off));
    e.link_data = r.pc + 32'd8;
    e.link_we   = r.link && ((r.mode == 4'd3) || (r.mode == 4'd6));
    e.branch_to = r.pc + 32'd8;
    e.taken     = 1'b0;
    e.redirect  = 1'b0;
    cnd = 1'b0;
    if (r.mode == 4'd1) cnd = r.z;
    if (r.mode == 4'd2) cnd = ~r.z;
    if (r.mode == 4'd3) cnd = r.z | r.p;
    if (r.mode == 4'd4) cnd = r.p;
    if (r.mode == 4'd5) cnd = r.z | r.n;
    if (r.mode == 4'd6) cnd = r.n;
    if (r.mode == 4'd7) cnd = r.c;
    if (r.mode == 4'd8) cnd = ~r.c;
    if (r.mode >= 4'd1 && r.mode <= 4'd8) begin
      e.taken    = cnd;
      e.redirect = cnd ^ r.pred;
      if (cnd) e.branch_to = nxt + 32'(so * 4);
    end else if (r.mode == 4'd9) begin
      e.taken     = 1'b1;
      e.redirect  = 1'b1;
      e.branch_to = (nxt & 32'hF000_0000) | {4'b0000, r.jt, 2'b00};
    end else if (r.mode == 4'd10) begin
      e.taken     = 1'b1;
      e.redirect  = 1'b1;
      e.branch_to = {r.jr[31:2], 2'b00};
    end
    return e;
  endfunction

  task automatic drive_req(input req_t r);
    mode = r.mode; link = r.link; pc = r.pc; offset = r.off; jump_target = r.jt;
    jr_addr = r.jr; result_zero = r.z; result_negative = r.n; result_positive = r.p;
    cp1_cond = r.c; predicted_taken = r.pred;
  endtask

  task automatic wait_accept(input exp_t e);
    int cyc;
    cyc = 0;
    in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      cyc++;
      if (cyc > 50) begin
        check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input req_t r, input exp_t e);
    drive_req(r);
    wait_accept(e);
  endtask

  // BNE at 0x40 (BHT index 0), front end always predicts taken
  task automatic bne_step(input logic t, input logic want_lk, input string tag);
    send(mk_req(MODE_BNE, 1'b0, 32'h40, 16'h0010, 26'h0, 32'h0, ~t, 1'b0, t, 1'b0, 1'b1),
         mk_exp(t, ~t, t ? 32'h84 : 32'h48, 1'b0, 32'h48));
    check(tag, 32'(lookup_taken), 32'(want_lk));
  endtask

  task automatic random_burst();
    req_t r;
    int   f;
    for (int k = 0; k < 30; k++) begin
      r.mode = 4'($urandom_range(0, 15));
      r.link = 1'($urandom_range(0, 1));
      r.pc   = $urandom;
      r.off  = 16'($urandom);
      r.jt   = 26'($urandom);
      r.jr   = $urandom;
      f      = $urandom_range(0, 2);
      r.z    = (f == 0);
      r.n    = (f == 1);
      r.p    = (f == 2);
      r.c    = 1'($urandom_range(0, 1));
      r.pred = 1'($urandom_range(0, 1));
      send(r, model(r));
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    lookup_pc = 32'h0;
    drive_req(mk_req(MODE_NONE, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_taken",     32'(taken),     32'd0);
    check("rst_redirect",  32'(redirect),  32'd0);
    check("rst_link_we",   32'(link_we),   32'd0);
    check("rst_branch_to", branch_to,      32'd0);
    check("rst_link_data", link_data,      32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_lookup",    32'(lookup_taken), 32'd0);
    @(posedge clk);
    #1;

    // BEQ backwards by one word onto itself; BHT[0] 01 -> 10
    lookup_pc = 32'h100;
    drive_req(mk_req(MODE_BEQ, 1'b0, 32'h100, 16'hFFFF, 26'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    #1;
    check("beq_lookup_pre", 32'(lookup_taken), 32'd0);
    wait_accept(mk_exp(1'b1, 1'b1, 32'h100, 1'b0, 32'h108));
    check("beq_lookup_post", 32'(lookup_taken), 32'd1);

    // BLTZAL not taken but still links; BHT[0] 10 -> 01
    lookup_pc = 32'h200;
    send(mk_req(MODE_BLTZ, 1'b1, 32'h200, 16'h0040, 26'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0),
         mk_exp(1'b0, 1'b0, 32'h208, 1'b1, 32'h208));
    check("bltzal_lookup", 32'(lookup_taken), 32'd0);

    // J into the top region; BHT must not be trained
    lookup_pc = 32'hF000_0000;
    send(mk_req(MODE_J, 1'b0, 32'hF000_0000, 16'h0, 26'h3FF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1),
         mk_exp(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hF000_0008));
    check("j_lookup", 32'(lookup_taken), 32'd0);

    // Saturation at both ends of BHT[0], starting from 01
    lookup_pc = 32'h40;
    bne_step(1'b1, 1'b1, "bne_t1");
    bne_step(1'b1, 1'b1, "bne_t2");
    bne_step(1'b1, 1'b1, "bne_t3_sat");
    bne_step(1'b1, 1'b1, "bne_t4_sat");
    bne_step(1'b0, 1'b1, "bne_nt_10");
    bne_step(1'b0, 1'b0, "bne_nt_01");
    bne_step(1'b0, 1'b0, "bne_nt_00");
    bne_step(1'b0, 1'b0, "bne_nt_sat");
    bne_step(1'b1, 1'b0, "bne_t_01");
    bne_step(1'b1, 1'b1, "bne_t_10");

    // Back-pressure: A held for 3 cycles, B waits, then both drain in order
    @(posedge clk);
    #1;
    ready_cmd = 1'b0;
    send(mk_req(MODE_BEQ, 1'b0, 32'h304, 16'h0002, 26'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1),
         mk_exp(1'b1, 1'b0, 32'h310, 1'b0, 32'h30C));
    drive_req(mk_req(MODE_JR, 1'b0, 32'h400, 16'h0, 26'h0, 32'h1234_5677, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid",    32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready),  32'd0);
      check("hold_target",   branch_to,      32'h310);
    end
    @(posedge clk);
    #1;
    ready_cmd = 1'b1;
    wait_accept(mk_exp(1'b1, 1'b1, 32'h1234_5674, 1'b0, 32'h408));

    // Reset while a result is held: result dropped, BHT back to weakly not-taken
    @(posedge clk);
    #1;
    ready_cmd = 1'b0;
    lookup_pc = 32'h104;
    send(mk_req(MODE_BEQ, 1'b0, 32'h104, 16'h0001, 26'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1),
         mk_exp(1'b1, 1'b0, 32'h10C, 1'b0, 32'h10C));
    check("pre_reset_valid",  32'(out_valid),    32'd1);
    check("pre_reset_lookup", 32'(lookup_taken), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    check("post_reset_valid",    32'(out_valid), 32'd0);
    check("post_reset_in_ready", 32'(in_ready),  32'd1);
    for (int i = 0; i < 16; i++) begin
      lookup_pc = 32'(i) << 2;
      #1;
      check("post_reset_lookup", 32'(lookup_taken), 32'd0);
    end
    ready_cmd = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic under random back-pressure
    rnd_bp = 1'b1;
    random_burst();
    rnd_bp = 1'b0;
    @(posedge clk);
    #3;
    for (int w = 0; w < 100 && sb_q.size() != 0; w++) @(posedge clk);
    @(negedge clk);
    check("drain_empty", 32'(sb_q.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
